apb_mem_bridge: RTL

//  APB4 completer bridging one APB port to a single-port word memory with a req/ready handshake.

---
 rtl/apb_pkg.sv | 30 +++
 rtl/apb_mem_bridge.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/apb_pkg.sv
// Shared types and sizing helpers for the APB-to-memory bridge.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MEM   = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } apb_bridge_state_t;

    localparam logic APB_OKAY = 1'b0;
    localparam logic APB_ERR  = 1'b1;

    function automatic int calc_nb(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int calc_al(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int calc_mem_aw(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int calc_cnt_w(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/apb_mem_bridge.sv
// APB4 completer in front of a single-port word memory with a req/ready handshake,
// with byte strobes, PSLVERR, a wait-state timeout and master-abort draining.
module apb_mem_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 16,
    parameter int TIMEOUT   = 16,
    localparam int NB       = calc_nb(DATA_W),
    localparam int AL       = calc_al(DATA_W),
    localparam int MEM_AW   = calc_mem_aw(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic              pwrite_i,
    input  logic [DATA_W-1:0] pwdata_i,
    input  logic [NB-1:0]     pstrb_i,
    output logic [DATA_W-1:0] prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    output logic              mem_req_o,
    output logic              mem_rnw_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [NB-1:0]     mem_be_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int                CNT_W      = calc_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(NB - 1);
    localparam int unsigned       DEPTH_U    = MEM_DEPTH;

    apb_bridge_state_t r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;
    logic [DATA_W-1:0] r_resp_data;
    logic [DATA_W-1:0] r_prdata_hold;
    logic              r_req;
    logic              r_rnw;
    logic [MEM_AW-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [NB-1:0]     r_be;

    logic              w_setup;
    logic              w_access;
    logic              w_misaligned;
    logic              w_out_of_range;
    logic              w_timeout;
    logic              w_pready;
    logic [ADDR_W-1:0] w_word_idx;

    assign w_setup        = psel_i & ~penable_i;
    assign w_access       = psel_i & penable_i;
    assign w_misaligned   = (paddr_i & ALIGN_MASK) != '0;
    assign w_word_idx     = paddr_i >> AL;
    assign w_out_of_range = 32'(w_word_idx) >= DEPTH_U;
    assign w_timeout      = (TIMEOUT > 0) && (r_cnt == CNT_LAST) && !mem_ready_i;

    // The completion pulse has to coincide with the master's access phase, which
    // cannot be known a cycle ahead, so pready is decoded from RESP and the bus.
    assign w_pready  = (r_state == ST_RESP) && w_access;
    assign pready_o  = w_pready;
    assign pslverr_o = w_pready & r_err;
    assign prdata_o  = w_pready ? r_resp_data : r_prdata_hold;

    assign mem_req_o   = r_req;
    assign mem_rnw_o   = r_rnw;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_be_o    = r_be;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_err         <= APB_OKAY;
            r_resp_data   <= '0;
            r_prdata_hold <= '0;
            r_req         <= 1'b0;
            r_rnw         <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_be          <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_setup) begin
                        r_rnw   <= ~pwrite_i;
                        r_addr  <= paddr_i[AL+MEM_AW-1:AL];
                        r_wdata <= pwdata_i;
                        r_be    <= pwrite_i ? pstrb_i : '0;
                        r_cnt   <= '0;
                        if (w_misaligned || w_out_of_range) begin
                            r_err       <= APB_ERR;
                            r_resp_data <= '0;
                            r_state     <= ST_RESP;
                        end else if (pwrite_i && (pstrb_i == '0)) begin
                            r_err       <= APB_OKAY;
                            r_resp_data <= '0;
                            r_state     <= ST_RESP;
                        end else begin
                            r_req   <= 1'b1;
                            r_state <= ST_MEM;
                        end
                    end
                end
                ST_MEM: begin
                    if (mem_ready_i) begin
                        r_req       <= 1'b0;
                        r_err       <= APB_OKAY;
                        r_resp_data <= r_rnw ? mem_rdata_i : '0;
                        r_state     <= ST_RESP;
                    end else if (w_timeout) begin
                        r_req       <= 1'b0;
                        r_err       <= APB_ERR;
                        r_resp_data <= '0;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (!psel_i) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Master has gone; finish the memory handshake without answering.
                    if (mem_ready_i || w_timeout) begin
                        r_req   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (!psel_i) begin
                        r_state <= ST_IDLE;
                    end else if (penable_i) begin
                        r_prdata_hold <= r_resp_data;
                        r_state       <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
